register_bank_4x46: RTL
=======================

# register_bank_4x46

Four-entry bank of 46-bit registers that directly feeds the 4:1 46-bit read-select mux. It drives all four register values in parallel on R0..R3, and the mux chooses among them with its 2-bit address. The block owns the write port, per-register written flags, and a busy scoreboard. The issue stage uses the scoreboard to detect write-after-write hazards before it reserves a destination register.

## Interface
- No parameters; width 46 and depth 4 are fixed.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- WE  input  1  write enable
- WA  input  2  write address
- D  input  46  write data
- RSV  input  1  reserve request from issue stage
- RA  input  2  reserve address
- CLR  input  1  synchronous clear of all registers and flags
- R0, R1, R2, R3  output  46 each  register contents, to mux inputs R0..R3
- VLD  output  4  bit n = register n written since last reset/clear
- BUSY  output  4  bit n = register n reserved, write outstanding
- STALL  output  1  reserve request rejected this cycle (combinational)

## Operation
- Storage: reg[0..3] 46 bits; vld[3:0]; busy[3:0]; all registered.
- Write: WE=1 at posedge loads reg[WA]<=D and sets vld[WA]<=1. It also clears busy[WA], unless the same register is reserved in the same cycle.
- Writes are accepted regardless of busy state; a write to a non-busy register is legal and leaves busy[WA]=0.
- Reserve: STALL = RSV & busy[RA] & ~(WE & WA==RA).
  - Reserve is accepted when RSV & ~STALL; an accepted reserve sets busy[RA]<=1.
  - A rejected reserve changes no state. The issue stage holds RSV/RA and retries.
- Simultaneous write and reserve, same address: the write lands, vld sets, busy ends 1 (new producer). STALL=0 for that cycle.
- Simultaneous write and reserve, different addresses: both take effect independently.
- CLR=1: at the next edge, all reg<=0, vld<=0, busy<=0. CLR has priority over WE and RSV in that cycle. STALL is forced to 0 while CLR=1.
- Outputs R0..R3 are the reg contents. VLD and BUSY are the flag registers.

## Timing
- Reset (rst_n=0, asynchronous, immediate): R0..R3=0, VLD=4'b0000, BUSY=4'b0000. STALL=0 while in reset.
- Reset deassertion is synchronised externally. First legal write is the first rising edge with rst_n=1.
- Write latency: data on D at edge k appears on Rn after edge k (1 cycle) with bypass disabled.
- BUSY/VLD update on the same edge as the write/reserve.
- STALL is combinational from RSV, RA, WE, WA, busy, with no registered delay.
- Reset mid-operation: all outstanding reservations and in-flight writes are discarded. An edge coinciding with rst_n=0 does not capture.
- No back-pressure on writes; the write port always accepts.

## Configuration
- Macro REG_BANK_WRITE_BYPASS_EN.
- Defined: when WE=1, output R[WA] combinationally shows D in the same cycle (0-cycle read-after-write). The other outputs are unaffected. Registered state is identical to the undefined case. CLR=1 suppresses bypass and outputs show the registered values.
- Undefined: R0..R3 are purely registered, with 1-cycle write visibility.

## Test plan
- Reset check: assert rst_n=0 mid-run after writing 46'h3FFF_FFFF_FFFF to reg2 → immediately R0..R3=0, VLD=0, BUSY=0, STALL=0.
- Write sweep: write D=46'h1, 46'h2AAA_AAAA_AAAA, 46'h1555_5555_5555, 46'h3FFF_FFFF_FFFF to WA=0..3 on consecutive edges → each value appears on R0..R3 one cycle later and VLD steps 0001→0011→0111→1111.
- Scoreboard: RSV RA=1 → BUSY=0010. Then RSV RA=1 again → STALL=1 and BUSY unchanged. Then WE WA=1 D=46'h5 → R1=5, BUSY=0000.
- Same-cycle collision: busy[3]=1, then WE WA=3 with RSV RA=3 in the same cycle → STALL=0, R3=D, BUSY[3]=1, VLD[3]=1.
- Clear priority: CLR=1 with WE WA=0 D=46'h7 and RSV RA=2 → after the edge all R=0, VLD=0, BUSY=0, STALL=0 during CLR.
- Bypass (build with REG_BANK_WRITE_BYPASS_EN): WE WA=2 D=46'h123 → R2=46'h123 in the same cycle and R0/R1/R3 unchanged. Without the macro, R2 changes only after the edge.

Source files
------------

// File: rtl/register_bank_4x46.sv
// Four 46-bit registers with write port, per-register written flags and a
// write-after-write busy scoreboard. Optional same-cycle write bypass: REG_BANK_WRITE_BYPASS_EN.
module register_bank_4x46 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE,
  input  logic [1:0]  WA,
  input  logic [45:0] D,
  input  logic        RSV,
  input  logic [1:0]  RA,
  input  logic        CLR,
  output logic [45:0] R0,
  output logic [45:0] R1,
  output logic [45:0] R2,
  output logic [45:0] R3,
  output logic [3:0]  VLD,
  output logic [3:0]  BUSY,
  output logic        STALL
);

  localparam int unsigned W = 46;
  localparam int unsigned N = 4;

  logic [W-1:0] regs_q [N];
  logic [W-1:0] rd     [N];
  logic [N-1:0] vld_q;
  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;
  logic [N-1:0] wr_dec;
  logic [N-1:0] rsv_dec;
  logic         stall;
  logic         rsv_acc;

  // Reserve arbitration: a write to the same register frees it for the new producer.
  always_comb begin
    wr_dec  = '0;
    rsv_dec = '0;
    stall   = RSV & busy_q[RA] & ~(WE & (WA == RA)) & ~CLR;
    rsv_acc = RSV & ~stall & ~CLR;
    if (WE)      wr_dec[WA]  = 1'b1;
    if (rsv_acc) rsv_dec[RA] = 1'b1;
    busy_d = (busy_q & ~wr_dec) | rsv_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      vld_q  <= '0;
      busy_q <= '0;
    end else if (CLR) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      vld_q  <= '0;
      busy_q <= '0;
    end else begin
      if (WE) regs_q[WA] <= D;
      vld_q  <= vld_q | wr_dec;
      busy_q <= busy_d;
    end
  end

  // Read view: registered contents, optionally overlaid with the in-flight write.
  always_comb begin
    for (int i = 0; i < N; i++) rd[i] = regs_q[i];
`ifdef REG_BANK_WRITE_BYPASS_EN
    if (WE && !CLR) rd[WA] = D;
`endif
  end

  assign R0    = rd[0];
  assign R1    = rd[1];
  assign R2    = rd[2];
  assign R3    = rd[3];
  assign VLD   = vld_q;
  assign BUSY  = busy_q;
  assign STALL = stall;

endmodule
